// File: rtl/rx_ibuf_wr_ctrl_pkg.sv
// rx_ibuf_wr_ctrl_pkg: shared state encodings and constants for the rx buffer write side
package rx_ibuf_wr_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_HDR, ST_DROP} state_t;
    localparam int HDR_LEN_W   = 16;
    localparam int IBUF_WR_LAT = 2;
endpackage

// File: rtl/rx_keep2len.sv
// rx_keep2len: byte count of a tkeep mask
module rx_keep2len (
    input  logic [7:0] keep,
    output logic [3:0] len
);
    always_comb begin
        len = '0;
        for (int i = 0; i < 8; i++) len = len + {3'b0, keep[i]};
    end
endmodule

// File: rtl/rx_ibuf_wr_ctrl.sv
// rx_ibuf_wr_ctrl: stores MAC frames as header+data in the rx buffer and publishes a committed pointer
module rx_ibuf_wr_ctrl
    import rx_ibuf_wr_ctrl_pkg::*;
#(
    parameter int AW        = 10,
    parameter int DW        = 64,
    parameter int MAX_WORDS = 1200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_tvalid,
    input  logic [63:0]   s_tdata,
    input  logic [7:0]    s_tkeep,
    input  logic          s_tlast,
    input  logic          s_tuser,
    output logic [AW-1:0] ibuf_a,
    output logic [DW-1:0] ibuf_d,
    input  logic [AW:0]   rd_ptr,
    output logic [AW:0]   wr_commit,
    output logic [31:0]   cnt_ok,
    output logic [31:0]   cnt_full,
    output logic [31:0]   cnt_bad
);
    localparam int NW = $clog2(MAX_WORDS + 1);

    state_t                          state, state_n;
    logic [AW:0]                     wr_ptr, wr_ptr_n, start, start_n, free, wr_addr;
    logic [NW-1:0]                   nwords, nwords_n;
    logic [HDR_LEN_W-1:0]            bytes, bytes_n, klen_w;
    logic [3:0]                      klen;
    logic [DW-1:0]                   wr_data;
    logic                            hdr_go, inc_full, inc_bad;
    logic [IBUF_WR_LAT-1:0]          pend_v;
    logic [IBUF_WR_LAT-1:0][AW:0]    pend_p;

    rx_keep2len u_keep2len (.keep(s_tkeep), .len(klen));

    assign klen_w = {{(HDR_LEN_W-4){1'b0}}, klen};
    // one slot stays reserved: the RAM is written every cycle at wr_ptr when idle
    assign free = (AW+1)'((1 << AW) - 1) - (wr_ptr - rd_ptr);

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        start_n  = start;
        nwords_n = nwords;
        bytes_n  = bytes;
        wr_addr  = wr_ptr;
        wr_data  = '0;
        hdr_go   = 1'b0;
        inc_full = 1'b0;
        inc_bad  = 1'b0;
        case (state)
            ST_IDLE: if (s_tvalid) begin
                if (free >= 2) begin
                    start_n  = wr_ptr;
                    wr_addr  = wr_ptr + 1;
                    wr_data  = s_tdata;
                    wr_ptr_n = wr_ptr + 2;
                    nwords_n = NW'(1);
                    bytes_n  = klen_w;
                    state_n  = s_tlast ? ST_HDR : ST_DATA;
                end else begin
                    inc_full = 1'b1;
                    state_n  = s_tlast ? ST_IDLE : ST_DROP;
                end
            end
            ST_DATA: if (s_tvalid) begin
                if (free == '0 || nwords == NW'(MAX_WORDS) || (s_tlast && s_tuser)) begin
                    wr_ptr_n = start;
                    inc_full = free == '0;
                    inc_bad  = free != '0;
                    state_n  = s_tlast ? ST_IDLE : ST_DROP;
                end else begin
                    wr_data  = s_tdata;
                    wr_ptr_n = wr_ptr + 1;
                    nwords_n = nwords + 1;
                    bytes_n  = bytes + klen_w;
                    state_n  = s_tlast ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                wr_addr = start;
                wr_data = {{(DW-HDR_LEN_W){1'b0}}, bytes};
                hdr_go  = 1'b1;
                inc_bad = s_tvalid;
                state_n = (s_tvalid && !s_tlast) ? ST_DROP : ST_IDLE;
            end
            default: if (s_tvalid && s_tlast) state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            start     <= '0;
            nwords    <= '0;
            bytes     <= '0;
            ibuf_a    <= '0;
            ibuf_d    <= '0;
            pend_v    <= '0;
            pend_p    <= '0;
            wr_commit <= '0;
            cnt_ok    <= '0;
            cnt_full  <= '0;
            cnt_bad   <= '0;
        end else begin
            state    <= state_n;
            wr_ptr   <= wr_ptr_n;
            start    <= start_n;
            nwords   <= nwords_n;
            bytes    <= bytes_n;
            ibuf_a   <= wr_addr[AW-1:0];
            ibuf_d   <= wr_data;
            // commit trails the header write by the RAM write latency
            pend_v   <= {pend_v[IBUF_WR_LAT-2:0], hdr_go};
            pend_p   <= {pend_p[IBUF_WR_LAT-2:0], wr_ptr};
            if (pend_v[IBUF_WR_LAT-1]) wr_commit <= pend_p[IBUF_WR_LAT-1];
            cnt_ok   <= cnt_ok + 32'(pend_v[0]);
            cnt_full <= cnt_full + 32'(inc_full);
            cnt_bad  <= cnt_bad + 32'(inc_bad);
        end
    end
endmodule

// File: tb/tb_rx_ibuf_wr_ctrl.sv
// tb_rx_ibuf_wr_ctrl: scoreboard bench with a frame-level reference model
module tb_rx_ibuf_wr_ctrl;
    localparam int AW        = 11;
    localparam int MAX_WORDS = 1200;
    localparam int RING      = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_tvalid = 1'b0;
    logic [63:0]   s_tdata = '0;
    logic [7:0]    s_tkeep = 8'hFF;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic [AW-1:0] ibuf_a;
    logic [63:0]   ibuf_d;
    logic [AW:0]   rd_ptr = '0;
    logic [AW:0]   wr_commit;
    logic [31:0]   cnt_ok, cnt_full, cnt_bad;

    rx_ibuf_wr_ctrl #(.AW(AW), .DW(64), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tuser(s_tuser), .ibuf_a(ibuf_a), .ibuf_d(ibuf_d), .rd_ptr(rd_ptr),
        .wr_commit(wr_commit), .cnt_ok(cnt_ok), .cnt_full(cnt_full), .cnt_bad(cnt_bad)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW:0] ptr;
        logic [AW:0] start;
        int          n;
        int          bytes;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] ram [RING];
    logic [63:0] exp_mem [RING];
    logic [AW:0] mwr = '0;
    logic [AW:0] last_commit = '0;
    int          mok = 0, mfull = 0, mbad = 0;
    int          errors = 0, checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: mirrors RAM writes, guards committed data, pops the scoreboard on each commit
    always @(negedge clk) begin
        if (reset) last_commit = wr_commit;
        else begin
            logic [AW:0]   used_c;
            logic [AW-1:0] off;
            int            bad;
            used_c = wr_commit - rd_ptr;
            off = ibuf_a - rd_ptr[AW-1:0];
            check("no_overwrite", 64'({1'b0, off} < used_c), 64'd0);
            ram[ibuf_a] = ibuf_d;
            if (wr_commit != last_commit) begin
                if (sb.size() == 0) check("unexpected_commit", 64'(wr_commit), 64'(last_commit));
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("commit_ptr", 64'(wr_commit), 64'(e.ptr));
                    check("header", ram[e.start[AW-1:0]], 64'(e.bytes));
                    bad = 0;
                    for (int i = 1; i <= e.n; i++)
                        if (ram[(int'(e.start) + i) % RING] !== exp_mem[(int'(e.start) + i) % RING]) bad++;
                    check("frame_data", 64'(bad), 64'd0);
                end
                last_commit = wr_commit;
            end
        end
    end

    // frame-level model: a frame needs n+1 slots; space shortfall is seen before the size limit
    task automatic send_frame(input int n, input bit u, input logic [7:0] lkeep, input bit gaps, input bit hdr_hit);
        logic [AW:0] used, st;
        logic [63:0] w;
        int          free0, res;
        exp_t        e;
        used  = mwr - rd_ptr;
        free0 = RING - 1 - int'(used);
        st    = mwr;
        if (hdr_hit) res = 2;
        else if (n + 1 > free0 && free0 <= MAX_WORDS + 1) res = 1;
        else if (n > MAX_WORDS || u) res = 2;
        else res = 0;
        for (int i = 1; i <= n; i++) begin
            while (gaps && i > 1 && $urandom_range(0, 4) == 0) begin
                s_tvalid = 1'b0;
                tick();
            end
            w = {$urandom, $urandom};
            s_tvalid = 1'b1;
            s_tdata  = w;
            s_tlast  = (i == n);
            s_tkeep  = (i == n) ? lkeep : 8'hFF;
            s_tuser  = (i == n) && u;
            if (res == 0) exp_mem[(int'(st) + i) % RING] = w;
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        if (res == 0) begin
            mwr     = st + (AW+1)'(n + 1);
            e.ptr   = mwr;
            e.start = st;
            e.n     = n;
            e.bytes = 8 * (n - 1) + $countones(lkeep);
            sb.push_back(e);
            mok++;
        end else if (res == 1) mfull++;
        else mbad++;
    endtask

    task automatic settle();
        int g = 0;
        while (sb.size() != 0 && g < 50) begin
            tick();
            g++;
        end
        repeat (3) tick();
        check("commit_drain", 64'(sb.size()), 64'd0);
        check("cnt_ok", 64'(cnt_ok), 64'(mok));
        check("cnt_full", 64'(cnt_full), 64'(mfull));
        check("cnt_bad", 64'(cnt_bad), 64'(mbad));
    endtask

    function automatic logic [7:0] rand_keep();
        int k = $urandom_range(1, 8);
        return 8'hFF >> (8 - k);
    endfunction

    initial begin
        repeat (3) tick();
        check("rst_ibuf_a", 64'(ibuf_a), 64'd0);
        check("rst_ibuf_d", ibuf_d, 64'd0);
        check("rst_commit", 64'(wr_commit), 64'd0);
        check("rst_cnts", 64'(cnt_ok | cnt_full | cnt_bad), 64'd0);
        reset = 1'b0;
        tick();

        send_frame(8, 1'b0, 8'h0F, 1'b0, 1'b0);
        tick();
        check("hdr_addr_H", 64'(ibuf_a), 64'd0);
        check("hdr_data_H", ibuf_d, 64'd60);
        check("cnt_ok_H", 64'(cnt_ok), 64'd0);
        tick();
        check("cnt_ok_H1", 64'(cnt_ok), 64'd1);
        check("commit_H1", 64'(wr_commit), 64'd0);
        tick();
        check("commit_H2", 64'(wr_commit), 64'd9);
        settle();

        send_frame(5, 1'b1, 8'h3F, 1'b1, 1'b0);
        settle();
        check("commit_after_bad", 64'(wr_commit), 64'd9);
        send_frame(3, 1'b0, 8'h01, 1'b0, 1'b0);
        settle();
        check("commit_reuse_start", 64'(wr_commit), 64'd13);

        send_frame(1205, 1'b0, 8'hFF, 1'b0, 1'b0);
        settle();
        send_frame(4, 1'b0, 8'h07, 1'b1, 1'b0);
        settle();

        send_frame(4, 1'b0, 8'hFF, 1'b0, 1'b0);
        send_frame(3, 1'b0, 8'hFF, 1'b0, 1'b1);
        settle();
        send_frame(2, 1'b0, 8'h1F, 1'b0, 1'b0);
        settle();

        rd_ptr = mwr - (AW+1)'(RING - 16);
        send_frame(10, 1'b0, 8'hFF, 1'b0, 1'b0);
        settle();
        send_frame(10, 1'b0, 8'hFF, 1'b0, 1'b0);
        settle();
        rd_ptr = rd_ptr + 11;
        send_frame(10, 1'b0, 8'h03, 1'b0, 1'b0);
        settle();

        for (int f = 0; f < 150; f++) begin
            int used;
            used = ($urandom_range(0, 3) == 0) ? $urandom_range(RING - 45, RING - 1) : $urandom_range(0, RING / 2);
            rd_ptr = mwr - (AW+1)'(used);
            send_frame($urandom_range(2, 40), $urandom_range(0, 7) == 0, rand_keep(), 1'b1, 1'b0);
            settle();
        end

        rd_ptr = mwr;
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {$urandom, $urandom};
            tick();
        end
        s_tvalid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_ibuf_a", 64'(ibuf_a), 64'd0);
        check("async_rst_ibuf_d", ibuf_d, 64'd0);
        check("async_rst_commit", 64'(wr_commit), 64'd0);
        check("async_rst_cnts", 64'(cnt_ok | cnt_full | cnt_bad), 64'd0);
        sb.delete();
        mwr = '0;
        mok = 0;
        mfull = 0;
        mbad = 0;
        rd_ptr = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        send_frame(6, 1'b0, 8'h7F, 1'b0, 1'b0);
        settle();
        check("commit_after_rst", 64'(wr_commit), 64'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
